// File: rtl/bpu_dyn.sv
// Dynamic branch predictor for the fetch stage: a table of 2-bit saturating counters
// indexed bimodally or by gshare, with a static backward-taken fallback, plus JAL decode.
module bpu_dyn #(
  parameter int         MODE    = 2,
  parameter int         IDX_W   = 6,
  parameter int         GHR_W   = 6,
  parameter logic [1:0] CTR_RST = 2'b01
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [63:0]      pc,
  input  logic [31:0]      ir,
  output logic             jal_taken,
  output logic [63:0]      jal_addr,
  output logic             pr_taken,
  output logic [12:0]      pr_offs,
  output logic [IDX_W-1:0] pr_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic [GHR_W-1:0] ghr
);

  localparam int         DEPTH  = 1 << IDX_W;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [1:0]       bht [DEPTH];
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_nxt;
  logic [20:0]      j_imm;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] fetch_idx;
  logic             is_br;

  assign j_imm     = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign jal_taken = (ir[6:0] == OP_JAL);
  assign jal_addr  = pc + {{43{j_imm[20]}}, j_imm};
  assign pr_offs   = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign is_br     = (ir[6:0] == OP_BR);
  assign pc_idx    = pc[IDX_W+1:2];
  assign pr_idx    = fetch_idx;
  assign ghr       = ghr_q;

  // Prediction reads the table before any same-cycle update lands (no bypass).
  always_comb begin
    fetch_idx = pc_idx;
    pr_taken  = 1'b0;
    if (MODE == 0) begin
      fetch_idx = '0;
      pr_taken  = is_br & ir[31];
    end else begin
      if (MODE == 2) fetch_idx = pc_idx ^ IDX_W'(ghr_q);
      pr_taken = is_br & bht[fetch_idx][1];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= CTR_RST;
    end else if (upd_valid && (MODE != 0)) begin
      if (upd_taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  // History is non-speculative: it only shifts when EX resolves a branch.
  if (GHR_W > 1) begin : g_ghr_wide
    assign ghr_nxt = {ghr_q[GHR_W-2:0], upd_taken};
  end else begin : g_ghr_one
    assign ghr_nxt = upd_taken;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ghr_q <= '0;
    end else if ((MODE == 2) && upd_valid) begin
      ghr_q <= ghr_nxt;
    end
  end

endmodule

// File: tb/tb_bpu_dyn.sv
// Bench for bpu_dyn: static, bimodal and gshare instances share stimulus and are
// checked every cycle against an arithmetic model, plus hand-computed spot checks.
module tb_bpu_dyn;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [63:0] pc;
  logic [31:0] ir;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;

  logic        jt [3];
  logic [63:0] ja [3];
  logic        pt [3];
  logic [12:0] po [3];
  logic [5:0]  pi [3];
  logic [5:0]  gh [3];

  int errors = 0;
  int checks = 0;

  int mb [64];
  int mg [64];
  int mghr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bpu_dyn #(.MODE(g), .IDX_W(6), .GHR_W(6), .CTR_RST(2'b01)) u_dut (
      .clk(clk), .clr_n(clr_n), .pc(pc), .ir(ir),
      .jal_taken(jt[g]), .jal_addr(ja[g]), .pr_taken(pt[g]), .pr_offs(po[g]),
      .pr_idx(pi[g]), .upd_valid(upd_valid), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .ghr(gh[g])
    );
  end

  // Reference: counters as plain integers clamped to 0..3, history as an integer mod 64.
  always @(posedge clk or negedge clr_n) begin
    int k;
    if (!clr_n) begin
      for (int i = 0; i < 64; i++) begin
        mb[i] = 1;
        mg[i] = 1;
      end
      mghr = 0;
    end else if (upd_valid) begin
      k = int'(upd_idx);
      if (upd_taken) begin
        mb[k] = (mb[k] + 1 > 3) ? 3 : mb[k] + 1;
        mg[k] = (mg[k] + 1 > 3) ? 3 : mg[k] + 1;
      end else begin
        mb[k] = (mb[k] - 1 < 0) ? 0 : mb[k] - 1;
        mg[k] = (mg[k] - 1 < 0) ? 0 : mg[k] - 1;
      end
      mghr = (mghr * 2 + int'(upd_taken)) % 64;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    longint unsigned iru, jimm_u, offs;
    longint          jimm;
    logic [63:0]     exp_ja;
    int              ib, idx, ctr;
    bit              is_br, is_jal, exp_pt;
    iru    = longint'(ir) & 64'hFFFF_FFFF;
    is_br  = (iru % 128) == 99;
    is_jal = (iru % 128) == 111;
    jimm_u = (((iru >> 21) & 'h3FF) << 1) | (((iru >> 20) & 1) << 11) |
             (((iru >> 12) & 'hFF) << 12);
    jimm   = longint'(jimm_u);
    if ((iru >> 31) & 1) jimm = jimm - (longint'(1) << 20);
    exp_ja = pc + 64'(jimm);
    offs   = (((iru >> 31) & 1) << 12) | (((iru >> 7) & 1) << 11) |
             (((iru >> 25) & 63) << 5) | (((iru >> 8) & 15) << 1);
    ib     = int'((pc >> 2) % 64);
    for (int m = 0; m < 3; m++) begin
      if (m == 0) begin
        idx    = 0;
        exp_pt = is_br && ((iru >> 31) & 1);
      end else begin
        idx    = (m == 1) ? ib : (ib ^ mghr);
        ctr    = (m == 1) ? mb[idx] : mg[idx];
        exp_pt = is_br && (ctr >= 2);
      end
      cmp($sformatf("m%0d jal_taken", m), 64'(jt[m]), 64'(is_jal));
      cmp($sformatf("m%0d jal_addr", m), ja[m], exp_ja);
      cmp($sformatf("m%0d pr_offs", m), 64'(po[m]), 64'(offs));
      cmp($sformatf("m%0d pr_idx", m), 64'(pi[m]), 64'(idx));
      cmp($sformatf("m%0d pr_taken", m), 64'(pt[m]), 64'(exp_pt));
      cmp($sformatf("m%0d ghr", m), 64'(gh[m]), (m == 2) ? 64'(mghr) : 64'd0);
    end
  endtask

  always @(negedge clk) check_all();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply n consecutive updates starting from just after a rising edge.
  task automatic upd_n(input int idx, input bit t, input int n);
    upd_valid = 1'b1;
    upd_idx   = 6'(idx);
    upd_taken = t;
    repeat (n) step();
    upd_valid = 1'b0;
  endtask

  localparam logic [31:0] BEQ_FWD = 32'h0000_0463;
  localparam logic [31:0] BEQ_BWD = 32'hFE00_0EE3;
  localparam logic [31:0] JAL_8   = 32'h0080_006F;

  initial begin
    logic [5:0] hist_bits;
    clr_n = 1'b0; pc = 64'h100; ir = BEQ_FWD;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    repeat (2) step();
    clr_n = 1'b1;

    @(negedge clk);
    cmp("t1 pr_taken", 64'(pt[1]), 64'd0);
    cmp("t1 pr_idx", 64'(pi[1]), 64'h00);
    cmp("t1 pr_offs", 64'(po[1]), 64'h008);

    step(); pc = 64'h14; upd_n(5, 1'b1, 2);
    @(negedge clk); cmp("t2 two taken", 64'(pt[1]), 64'd1);
    step(); upd_n(5, 1'b1, 4);
    @(negedge clk); cmp("t2 saturate high", 64'(pt[1]), 64'd1);
    step(); upd_n(5, 1'b0, 3);
    @(negedge clk); cmp("t2 three not-taken", 64'(pt[1]), 64'd0);
    step(); upd_n(5, 1'b0, 1);
    step(); upd_n(5, 1'b1, 1);
    @(negedge clk); cmp("t2 no wrap low 01", 64'(pt[1]), 64'd0);
    step(); upd_n(5, 1'b1, 1);
    @(negedge clk); cmp("t2 no wrap low 10", 64'(pt[1]), 64'd1);

    step(); ir = BEQ_BWD;
    @(negedge clk);
    cmp("t3 static taken", 64'(pt[0]), 64'd1);
    cmp("t3 static offs", 64'(po[0]), 64'h1FFC);
    step(); upd_n(0, 1'b0, 3);
    @(negedge clk); cmp("t3 static ignores table", 64'(pt[0]), 64'd1);

    step(); ir = BEQ_FWD;
    hist_bits = 6'b001011;
    upd_valid = 1'b1; upd_idx = 6'd40;
    for (int b = 5; b >= 0; b--) begin
      upd_taken = hist_bits[b];
      step();
    end
    upd_valid = 1'b0; pc = 64'h40;
    @(negedge clk);
    cmp("t4 ghr", 64'(gh[2]), 64'h0B);
    cmp("t4 gshare idx", 64'(pi[2]), 64'h1B);
    cmp("t4 bimodal ghr", 64'(gh[1]), 64'h00);

    step(); pc = 64'h0C; upd_valid = 1'b1; upd_idx = 6'd3; upd_taken = 1'b1;
    @(negedge clk); cmp("t5 same-cycle pre", 64'(pt[1]), 64'd0);
    step(); upd_valid = 1'b0;
    @(negedge clk); cmp("t5 next-cycle post", 64'(pt[1]), 64'd1);

    for (int n = 0; n < 800; n++) begin
      step();
      pc = {$urandom, $urandom};
      if ($urandom_range(0, 1)) pc[7:2] = 6'($urandom_range(0, 7));
      ir = $urandom;
      case ($urandom_range(0, 3))
        0, 1: ir[6:0] = 7'b1100011;
        2:    ir[6:0] = 7'b1101111;
        default: ;
      endcase
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_idx   = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      upd_taken = 1'($urandom_range(0, 1));
    end

    step(); upd_valid = 1'b1; upd_idx = 6'd5; upd_taken = 1'b1;
    #2 clr_n = 1'b0;
    #1;
    cmp("t6 ghr async clear", 64'(gh[2]), 64'h00);
    ir = BEQ_FWD;
    for (int k = 0; k < 64; k++) begin
      pc = 64'(k) << 2;
      #1;
      cmp($sformatf("t6 bimodal ctr %0d", k), 64'(pt[1]), 64'd0);
      cmp($sformatf("t6 gshare ctr %0d", k), 64'(pt[2]), 64'd0);
    end
    pc = 64'h200; ir = JAL_8;
    #1;
    cmp("t6 jal_taken", 64'(jt[1]), 64'd1);
    cmp("t6 jal_addr", ja[1], 64'h208);

    step(); clr_n = 1'b1; upd_valid = 1'b0;
    step(); pc = 64'(9) << 2; ir = BEQ_FWD; upd_n(9, 1'b1, 1);
    @(negedge clk); cmp("t6 reset value 01", 64'(pt[1]), 64'd1);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
